fsb_burst_arbiter: RTL and testbench
====================================

# fsb_burst_arbiter

Parametrised round-robin arbiter that merges the per-hart instruction- and data-cache refill/writeback channels of `NUM_HARTS` cores onto one shared memory-side bus. It generalises the single-core arrangement, where one icache and one dcache each own a bus controller port, to `2*NUM_HARTS` channels with block bursts and per-hart abort. It sits between the cache miss handlers of every hart and the single memory controller.

## Interface
Parameters:
- `NUM_HARTS`, 2: harts served; channel count `NCH = 2*NUM_HARTS`; channel `2h` = hart h icache, `2h+1` = hart h dcache.
- `BLOCK_SIZE`, 4: 32-bit words per burst, power of two, 1..16.
- `ADDR_W`, 32: address width.

Ports (`[NCH]` = one per channel, flattened, channel 0 in LSBs):
- `CLK`  in  1  clock; all logic on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `ch_ren`  in  NCH  block read request.
- `ch_wen`  in  NCH  block write request; `ren` and `wen` both high counts as `ren`.
- `ch_addr`  in  NCH*ADDR_W  block base address; low `log2(BLOCK_SIZE)+2` bits ignored.
- `ch_wdata`  in  NCH*BLOCK_SIZE*32  write block, word 0 in LSBs.
- `ch_busy`  out  NCH  high while a request is pending or in service.
- `ch_rdata`  out  BLOCK_SIZE*32  read block shared by all channels; valid in the `ch_done` cycle.
- `ch_done`  out  NCH  one-cycle completion pulse.
- `abort`  in  NUM_HARTS  cancels the in-service burst of hart h (both channels).
- `mem_ren`, `mem_wen`  out  1  memory beat request.
- `mem_addr`  out  ADDR_W  beat address.
- `mem_wdata`  out  32  beat write data.
- `mem_busy`  in  1  low = current beat accepted/completed this cycle.
- `mem_rdata`  in  32  read beat data, valid when `mem_busy` low.

## Operation
- States: `IDLE`, `BURST`, `FINISH`.
- `IDLE`: when any channel has `ren|wen`, select the first requesting channel at or after `rr_ptr` (wrapping modulo `NCH`). Latch channel, direction, and aligned base address. Clear beat counter. Go to `BURST`.
- `BURST`: drive `mem_ren` or `mem_wen`, with `mem_addr = base + 4*beat` and `mem_wdata = word[beat]` of the latched channel's `ch_wdata`.
  - On `mem_busy` low: store the read beat into `ch_rdata` word[beat], then increment `beat`.
  - After beat `BLOCK_SIZE-1` completes, go to `FINISH`.
- `FINISH`: pulse `ch_done` for the granted channel, set `rr_ptr = grant+1` (wraps to 0), go to `IDLE`.
- `ch_busy[c]` = `(ren|wen)[c]` and not (`FINISH` state with grant = c).
- Abort or request drop:
  - Abort applies when `abort[h]` is high, or the granted channel drops `ren|wen`, during `BURST`.
  - A beat already presented is held until `mem_busy` is low. No further beats are issued.
  - Then go to `IDLE` with no `ch_done`, and set `rr_ptr = grant+1`.
  - If the abort arrives in the cycle the last beat completes, the burst completes normally.
  - `abort` for a non-granted hart has no effect.
- Address arithmetic is modulo `2^ADDR_W`. The beat counter is `log2(BLOCK_SIZE)` bits (minimum 1).
- Fairness: any channel holding its request is granted within `NCH-1` bursts of other channels.

## Timing
- Reset values:
  - State `IDLE`, `rr_ptr` = 0, beat = 0.
  - `mem_ren`, `mem_wen`, `ch_done` = 0.
  - `mem_addr`, `mem_wdata`, `ch_rdata` = 0.
  - `ch_busy` follows its combinational definition.
- Reset mid-burst: memory strobes drop in the next cycle and no `ch_done` is issued.
- Latency:
  - Request seen in `IDLE` at cycle t → beat 0 on `mem_*` at t+1.
  - With zero-wait memory, `ch_done` at t+1+BLOCK_SIZE.
  - Next grant evaluated at t+2+BLOCK_SIZE.
- Memory strobes, address and wdata are registered or state-decoded and stay stable while `mem_busy` is high.
- Only one burst is in flight at any time. There are no back-to-back grants without an `IDLE` cycle.

## Test plan
- Single read, NUM_HARTS=2, BLOCK_SIZE=4: ch1 reads 0x8000_0010, zero-wait memory returning addr^0xFFFF → `mem_addr` 0x8000_0010, 0x14, 0x18, 0x1C on consecutive cycles; `ch_done[1]` after 5 cycles; `ch_rdata` word i = addr_i^0xFFFF.
- Round-robin: channels 0, 2 and 3 request continuously → grant order 0, 2, 3, 0, 2, 3; no channel waits more than 3 bursts.
- Write with wait states: ch2 writes words 0xA0..0xA3, `mem_busy` high 2 cycles per beat → each word held stable through its wait cycles; `ch_done[2]` once, 12 cycles after beat 0.
- Abort: hart 1 (ch3) burst, `abort[1]` during beat 1 with `mem_busy` high → beat 1 completes, no beat 2, no `ch_done`, `rr_ptr` = 0; abort coinciding with last-beat completion → `ch_done[3]` pulses.
- Request drop and reset: ch0 drops `ren` mid-burst → treated as abort. `RST` high mid-burst → next cycle `mem_ren`=0, state `IDLE`, `rr_ptr`=0.

Source files
------------

// File: rtl/fsb_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fsb_burst_arbiter
// Brief    : Round-robin arbiter merging the icache/dcache block channels of
//            NUM_HARTS cores onto one shared memory beat bus.
// Revision : 1.0 - initial release
// ============================================================================
module fsb_burst_arbiter #(
    parameter int NUM_HARTS  = 2,
    parameter int BLOCK_SIZE = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [2*NUM_HARTS-1:0]                ch_ren,
    input  logic [2*NUM_HARTS-1:0]                ch_wen,
    input  logic [2*NUM_HARTS*ADDR_W-1:0]         ch_addr,
    input  logic [2*NUM_HARTS*BLOCK_SIZE*32-1:0]  ch_wdata,
    output logic [2*NUM_HARTS-1:0]                ch_busy,
    output logic [BLOCK_SIZE*32-1:0]              ch_rdata,
    output logic [2*NUM_HARTS-1:0]                ch_done,
    input  logic [NUM_HARTS-1:0]                  abort,
    output logic                                  mem_ren,
    output logic                                  mem_wen,
    output logic [ADDR_W-1:0]                     mem_addr,
    output logic [31:0]                           mem_wdata,
    input  logic                                  mem_busy,
    input  logic [31:0]                           mem_rdata
);

    localparam int c_nch = 2 * NUM_HARTS;
    localparam int c_gw  = (c_nch > 1) ? $clog2(c_nch) : 1;
    localparam int c_bw  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

    localparam logic [ADDR_W-1:0] c_align_mask = ~ADDR_W'(BLOCK_SIZE * 4 - 1);
    localparam logic [c_gw-1:0]   c_last_ch    = c_gw'(c_nch - 1);
    localparam logic [c_bw-1:0]   c_last_beat  = c_bw'(BLOCK_SIZE - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_burst  = 2'd1;
    localparam logic [1:0] c_st_finish = 2'd2;

    logic [1:0]               r_state;
    logic [c_gw-1:0]          r_grant;
    logic [c_gw-1:0]          r_rr_ptr;
    logic [c_bw-1:0]          r_beat;
    logic                     r_abort_pend;
    logic                     r_mem_ren;
    logic                     r_mem_wen;
    logic [ADDR_W-1:0]        r_mem_addr;
    logic [31:0]              r_mem_wdata;
    logic [BLOCK_SIZE*32-1:0] r_ch_rdata;
    logic [c_nch-1:0]         r_ch_done;

    logic [c_nch-1:0]  w_req;
    logic              w_found;
    logic [c_gw-1:0]   w_sel;
    logic              w_sel_ren;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_word0;
    logic              w_gnt_req;
    logic [31:0]       w_next_word;
    logic              w_abort_hit;
    logic              w_abort_now;
    logic [c_bw-1:0]   w_beat_nxt;
    logic              w_last_beat;
    logic [c_gw-1:0]   w_gnt_inc;

    assign w_req       = ch_ren | ch_wen;
    assign w_beat_nxt  = r_beat + c_bw'(1);
    assign w_last_beat = (r_beat == c_last_beat);
    assign w_gnt_inc   = (r_grant == c_last_ch) ? '0 : r_grant + c_gw'(1);
    assign w_abort_now = w_abort_hit | ~w_gnt_req;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int off = 0; off < c_nch; off++) begin
            for (int c = 0; c < c_nch; c++) begin
                if (!w_found && w_req[c] && (((int'(r_rr_ptr) + off) % c_nch) == c)) begin
                    w_found = 1'b1;
                    w_sel   = c_gw'(c);
                end
            end
        end
    end

    always_comb begin
        w_sel_ren   = 1'b0;
        w_sel_addr  = '0;
        w_sel_word0 = '0;
        w_gnt_req   = 1'b0;
        w_next_word = '0;
        w_abort_hit = 1'b0;
        for (int c = 0; c < c_nch; c++) begin
            if (w_sel == c_gw'(c)) begin
                w_sel_ren   = ch_ren[c];
                w_sel_addr  = ch_addr[c*ADDR_W +: ADDR_W];
                w_sel_word0 = ch_wdata[c*BLOCK_SIZE*32 +: 32];
            end
            if (r_grant == c_gw'(c)) begin
                w_gnt_req = w_req[c];
                for (int w = 0; w < BLOCK_SIZE; w++) begin
                    if (w_beat_nxt == c_bw'(w)) begin
                        w_next_word = ch_wdata[(c*BLOCK_SIZE + w)*32 +: 32];
                    end
                end
            end
        end
        for (int h = 0; h < NUM_HARTS; h++) begin
            if ((r_grant == c_gw'(2*h)) || (r_grant == c_gw'(2*h + 1))) begin
                w_abort_hit = abort[h];
            end
        end
    end

    always_comb begin
        ch_busy = '0;
        for (int c = 0; c < c_nch; c++) begin
            ch_busy[c] = w_req[c] & ~((r_state == c_st_finish) && (r_grant == c_gw'(c)));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= c_st_idle;
            r_grant      <= '0;
            r_rr_ptr     <= '0;
            r_beat       <= '0;
            r_abort_pend <= 1'b0;
            r_mem_ren    <= 1'b0;
            r_mem_wen    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_ch_rdata   <= '0;
            r_ch_done    <= '0;
        end else begin
            r_ch_done <= '0;
            case (r_state)
                c_st_idle: begin
                    if (w_found) begin
                        r_grant      <= w_sel;
                        r_beat       <= '0;
                        r_abort_pend <= 1'b0;
                        r_mem_ren    <= w_sel_ren;
                        r_mem_wen    <= ~w_sel_ren;
                        r_mem_addr   <= w_sel_addr & c_align_mask;
                        r_mem_wdata  <= w_sel_word0;
                        r_state      <= c_st_burst;
                    end
                end
                c_st_burst: begin
                    if (!mem_busy) begin
                        if (r_mem_ren) begin
                            for (int w = 0; w < BLOCK_SIZE; w++) begin
                                if (r_beat == c_bw'(w)) begin
                                    r_ch_rdata[w*32 +: 32] <= mem_rdata;
                                end
                            end
                        end
                        // An abort seen only on the final completing beat is ignored.
                        if (w_last_beat) begin
                            r_mem_ren <= 1'b0;
                            r_mem_wen <= 1'b0;
                            if (r_abort_pend) begin
                                r_rr_ptr <= w_gnt_inc;
                                r_state  <= c_st_idle;
                            end else begin
                                for (int c = 0; c < c_nch; c++) begin
                                    r_ch_done[c] <= (r_grant == c_gw'(c));
                                end
                                r_state <= c_st_finish;
                            end
                        end else if (r_abort_pend || w_abort_now) begin
                            r_mem_ren <= 1'b0;
                            r_mem_wen <= 1'b0;
                            r_rr_ptr  <= w_gnt_inc;
                            r_state   <= c_st_idle;
                        end else begin
                            r_beat      <= w_beat_nxt;
                            r_mem_addr  <= r_mem_addr + ADDR_W'(4);
                            r_mem_wdata <= w_next_word;
                        end
                    end else if (w_abort_now) begin
                        r_abort_pend <= 1'b1;
                    end
                end
                c_st_finish: begin
                    r_rr_ptr <= w_gnt_inc;
                    r_state  <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign mem_ren   = r_mem_ren;
    assign mem_wen   = r_mem_wen;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign ch_rdata  = r_ch_rdata;
    assign ch_done   = r_ch_done;

endmodule
`default_nettype wire

// File: tb/tb_fsb_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsb_burst_arbiter
// Brief    : Directed scoreboard bench for fsb_burst_arbiter with a wait-state
//            memory model returning addr^0xFFFF.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsb_burst_arbiter;

    localparam int NUM_HARTS  = 2;
    localparam int BLOCK_SIZE = 4;
    localparam int ADDR_W     = 32;
    localparam int NCH        = 2 * NUM_HARTS;

    typedef struct packed {
        logic [31:0] start;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } beat_t;

    typedef struct packed {
        logic [31:0]  cyc;
        logic [3:0]   mask;
        logic [127:0] rdata;
        logic [3:0]   busy;
    } done_t;

    logic                            CLK = 1'b0;
    logic                            RST;
    logic [NCH-1:0]                  ch_ren;
    logic [NCH-1:0]                  ch_wen;
    logic [NCH*ADDR_W-1:0]           ch_addr;
    logic [NCH*BLOCK_SIZE*32-1:0]    ch_wdata;
    logic [NCH-1:0]                  ch_busy;
    logic [BLOCK_SIZE*32-1:0]        ch_rdata;
    logic [NCH-1:0]                  ch_done;
    logic [NUM_HARTS-1:0]            abort;
    logic                            mem_ren;
    logic                            mem_wen;
    logic [ADDR_W-1:0]               mem_addr;
    logic [31:0]                     mem_wdata;
    logic                            mem_busy;
    logic [31:0]                     mem_rdata;

    fsb_burst_arbiter #(
        .NUM_HARTS  (NUM_HARTS),
        .BLOCK_SIZE (BLOCK_SIZE),
        .ADDR_W     (ADDR_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ch_ren    (ch_ren),
        .ch_wen    (ch_wen),
        .ch_addr   (ch_addr),
        .ch_wdata  (ch_wdata),
        .ch_busy   (ch_busy),
        .ch_rdata  (ch_rdata),
        .ch_done   (ch_done),
        .abort     (abort),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_busy  (mem_busy),
        .mem_rdata (mem_rdata)
    );

    always #5 CLK = ~CLK;

    assign mem_rdata = mem_addr ^ 32'h0000_FFFF;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nwait = 0;
    int wcnt = 0;
    int cur_start = 0;
    int drop_after = 1;
    int unstable = 0;
    logic        prev_hold = 1'b0;
    logic        prev_ren, prev_wen;
    logic [31:0] prev_addr, prev_wdata;

    beat_t exp_q[$];
    beat_t beat_q[$];
    done_t done_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs #1 after the edge and answer as the memory.
    task automatic tick();
        beat_t b;
        done_t d;
        @(posedge CLK);
        #1;
        cyc++;
        if (ch_done != '0) begin
            d.cyc   = 32'(cyc);
            d.mask  = ch_done;
            d.rdata = ch_rdata;
            d.busy  = ch_busy;
            done_q.push_back(d);
            if (done_q.size() >= drop_after) begin
                ch_ren = '0;
                ch_wen = '0;
            end
        end
        if (prev_hold && (mem_addr !== prev_addr || mem_wdata !== prev_wdata ||
                          mem_ren !== prev_ren || mem_wen !== prev_wen)) begin
            unstable++;
        end
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        prev_ren   = mem_ren;
        prev_wen   = mem_wen;
        if (mem_ren || mem_wen) begin
            if (wcnt == 0) cur_start = cyc;
            if (wcnt < nwait) begin
                mem_busy = 1'b1;
                wcnt++;
            end else begin
                mem_busy = 1'b0;
                wcnt = 0;
                b.start = 32'(cur_start);
                b.addr  = mem_addr;
                b.wr    = mem_wen;
                b.wdata = mem_wdata;
                beat_q.push_back(b);
            end
        end else begin
            mem_busy = 1'b0;
            wcnt = 0;
        end
        prev_hold = (mem_ren || mem_wen) && mem_busy;
    endtask

    task automatic push_burst(input int start, input logic [31:0] base, input logic wr,
                              input logic [31:0] wd0, input int step, input int nbeats);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.start = 32'(start + i * step);
            b.addr  = base + 32'(4 * i);
            b.wr    = wr;
            b.wdata = wd0 + 32'(i);
            exp_q.push_back(b);
        end
    endtask

    task automatic check_beats(input string tag);
        beat_t e, o;
        chk({tag, " beat_count"}, 128'(beat_q.size()), 128'(exp_q.size()));
        while (exp_q.size() > 0 && beat_q.size() > 0) begin
            e = exp_q.pop_front();
            o = beat_q.pop_front();
            chk({tag, " beat_addr"}, 128'(o.addr), 128'(e.addr));
            chk({tag, " beat_dir"}, 128'(o.wr), 128'(e.wr));
            chk({tag, " beat_start"}, 128'(o.start), 128'(e.start));
            if (e.wr) chk({tag, " beat_wdata"}, 128'(o.wdata), 128'(e.wdata));
        end
        exp_q.delete();
        beat_q.delete();
    endtask

    task automatic check_done(input string tag, input logic [3:0] mask, input int at,
                              input logic chk_rd, input logic [127:0] rd);
        done_t d;
        chk({tag, " done_count"}, 128'(done_q.size()), 128'(1));
        if (done_q.size() > 0) begin
            d = done_q.pop_front();
            chk({tag, " done_mask"}, 128'(d.mask), 128'(mask));
            chk({tag, " done_cycle"}, 128'(d.cyc), 128'(at));
            if (chk_rd) chk({tag, " rdata"}, d.rdata, rd);
        end
        done_q.delete();
    endtask

    task automatic wait_done(input string tag, input int n, input int budget);
        int i = 0;
        while (done_q.size() < n && i < budget) begin
            tick();
            i++;
        end
        checks++;
        assert (done_q.size() >= n)
        else begin
            failures++;
            $error("FAIL %s timeout observed=%0d expected=%0d", tag, done_q.size(), n);
        end
    endtask

    function automatic logic [127:0] exp_rdata(input logic [31:0] base);
        logic [127:0] r;
        for (int i = 0; i < BLOCK_SIZE; i++) r[i*32 +: 32] = (base + 32'(4 * i)) ^ 32'h0000_FFFF;
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2;
        int seq [3];
        RST = 1'b1; ch_ren = '0; ch_wen = '0; ch_addr = '0; ch_wdata = '0;
        abort = '0; mem_busy = 1'b0;

        // Reset state
        tick(); tick(); tick();
        RST = 1'b0;
        tick();
        chk("rst mem_ren", 128'(mem_ren), 128'(0));
        chk("rst mem_wen", 128'(mem_wen), 128'(0));
        chk("rst ch_done", 128'(ch_done), 128'(0));
        chk("rst mem_addr", 128'(mem_addr), 128'(0));
        chk("rst mem_wdata", 128'(mem_wdata), 128'(0));
        chk("rst ch_rdata", 128'(ch_rdata), 128'(0));
        chk("rst ch_busy", 128'(ch_busy), 128'(0));

        // Single zero-wait read on ch1
        ch_addr[1*32 +: 32] = 32'h8000_0010;
        ch_ren[1] = 1'b1;
        nwait = 0; drop_after = 1; done_q.delete(); beat_q.delete();
        k = cyc;
        push_burst(k + 1, 32'h8000_0010, 1'b0, 32'h0, 1, 4);
        tick();
        chk("rd1 busy_mid", 128'(ch_busy), 128'(4'b0010));
        wait_done("rd1", 1, 20);
        if (done_q.size() > 0) chk("rd1 busy_finish", 128'(done_q[0].busy[1]), 128'(0));
        tick(); tick();
        check_beats("rd1");
        check_done("rd1", 4'b0010, k + 5, 1'b1, exp_rdata(32'h8000_0010));

        // Round-robin among ch0, ch2, ch3 from a fresh pointer
        RST = 1'b1;
        tick();
        RST = 1'b0;
        ch_addr[0*32 +: 32] = 32'h0000_0100;
        ch_addr[2*32 +: 32] = 32'h0000_0200;
        ch_addr[3*32 +: 32] = 32'h0000_0300;
        ch_ren = 4'b1101;
        drop_after = 6; done_q.delete(); beat_q.delete();
        k = cyc;
        seq[0] = 0; seq[1] = 2; seq[2] = 3;
        wait_done("rr", 6, 100);
        tick(); tick();
        chk("rr done_count", 128'(done_q.size()), 128'(6));
        for (int j = 0; j < 6 && j < done_q.size(); j++) begin
            chk("rr grant", 128'(done_q[j].mask), 128'(4'b0001 << seq[j % 3]));
            chk("rr cycle", 128'(done_q[j].cyc), 128'(k + 5 + 6 * j));
        end
        done_q.delete(); beat_q.delete();

        // Write with two wait states per beat, unaligned request address
        for (int i = 0; i < BLOCK_SIZE; i++) ch_wdata[(2*BLOCK_SIZE + i)*32 +: 32] = 32'hA0 + 32'(i);
        ch_addr[2*32 +: 32] = 32'h0000_1007;
        ch_wen[2] = 1'b1;
        nwait = 2; drop_after = 1; unstable = 0;
        k = cyc;
        push_burst(k + 1, 32'h0000_1000, 1'b1, 32'hA0, 3, 4);
        wait_done("wr", 1, 60);
        tick(); tick(); tick();
        check_beats("wr");
        check_done("wr", 4'b0100, k + 13, 1'b0, 128'(0));
        chk("wr held_stable", 128'(unstable), 128'(0));

        // Abort hart 1 during a waiting beat 1; pointer must wrap to 0
        ch_addr[3*32 +: 32] = 32'h0000_2000;
        ch_ren[3] = 1'b1;
        nwait = 2; drop_after = 1;
        k = cyc;
        push_burst(k + 1, 32'h0000_2000, 1'b0, 32'h0, 3, 2);
        push_burst(k + 8, 32'h0000_3000, 1'b0, 32'h0, 1, 4);
        tick(); tick(); tick(); tick();
        abort = 2'b10;
        tick();
        abort = 2'b00;
        ch_addr[1*32 +: 32] = 32'h0000_3000;
        ch_ren[1] = 1'b1;
        tick(); tick();
        chk("abort strobe_drop", 128'({mem_ren, mem_wen}), 128'(0));
        chk("abort no_done", 128'(done_q.size()), 128'(0));
        nwait = 0;
        wait_done("abort", 1, 30);
        tick(); tick();
        check_beats("abort");
        check_done("abort", 4'b0010, k + 12, 1'b1, exp_rdata(32'h0000_3000));

        // Abort on last-beat completion completes; other hart's abort ignored
        ch_addr[3*32 +: 32] = 32'h0000_4000;
        ch_ren[3] = 1'b1;
        nwait = 0; drop_after = 1;
        k = cyc;
        push_burst(k + 1, 32'h0000_4000, 1'b0, 32'h0, 1, 4);
        tick(); tick();
        abort = 2'b01;
        tick();
        abort = 2'b00;
        tick();
        abort = 2'b10;
        tick();
        abort = 2'b00;
        tick(); tick();
        check_beats("abort_last");
        check_done("abort_last", 4'b1000, k + 5, 1'b1, exp_rdata(32'h0000_4000));

        // ch0 drops its request mid-burst
        ch_addr[0*32 +: 32] = 32'h0000_5000;
        ch_ren[0] = 1'b1;
        k = cyc;
        push_burst(k + 1, 32'h0000_5000, 1'b0, 32'h0, 1, 2);
        tick(); tick();
        ch_ren[0] = 1'b0;
        tick(); tick(); tick(); tick();
        check_beats("drop");
        chk("drop no_done", 128'(done_q.size()), 128'(0));
        chk("drop strobe", 128'({mem_ren, mem_wen}), 128'(0));

        // Reset mid-burst on ch2; pointer back to 0 gives ch0 priority over ch2
        ch_addr[2*32 +: 32] = 32'h0000_6000;
        ch_ren[2] = 1'b1;
        tick(); tick();
        RST = 1'b1;
        tick();
        chk("rst_mid strobe", 128'({mem_ren, mem_wen}), 128'(0));
        chk("rst_mid no_done", 128'(done_q.size()), 128'(0));
        RST = 1'b0;
        ch_addr[0*32 +: 32] = 32'h0000_7000;
        ch_ren = 4'b0101;
        drop_after = 1; done_q.delete(); beat_q.delete(); exp_q.delete();
        k2 = cyc;
        push_burst(k2 + 1, 32'h0000_7000, 1'b0, 32'h0, 1, 4);
        wait_done("rst_mid", 1, 20);
        tick(); tick();
        check_beats("rst_mid");
        check_done("rst_mid", 4'b0001, k2 + 5, 1'b1, exp_rdata(32'h0000_7000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
